// File: rtl/kbd_event_ctrl.sv
// kbd_event_ctrl: PS/2 set-2 scan-code parser with typematic repeat filter
// and a first-word-fall-through event FIFO for the downstream note logic.
//  state | meaning
//  IDLE  | waiting for the first byte of a sequence
//  E0    | extended prefix seen
//  F0    | break prefix seen
//  E0F0  | extended break prefix seen
//  SKIP  | discarding the remaining bytes of a Pause sequence
module kbd_event_ctrl #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 250000
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [7:0]                    rx_data_i,
  input  logic                          rx_ready_i,
  output logic                          ev_valid_o,
  output logic [9:0]                    ev_data_o,
  input  logic                          ev_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count_o,
  output logic                          overflow_o,
  input  logic                          clr_ovf_i,
  output logic                          busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_E0,
    S_F0,
    S_E0F0,
    S_SKIP
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      skip_q, skip_d;
  logic [TW-1:0]   to_q, to_d;
  logic            rdy_q;
  logic            stb;

  logic            gen, gen_brk, gen_ext;
  logic            held_vld_q, held_vld_d;
  logic [8:0]      held_key_q, held_key_d;
  logic            key_match;
  logic            push;

  logic [9:0]      mem_q [FIFO_DEPTH];
  logic [AW:0]     wr_q, rd_q;
  logic [AW:0]     count;
  logic            full, pop, wr_en;
  logic            ovf_q;

  assign stb = rx_ready_i & ~rdy_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      skip_q  <= '0;
      to_q    <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      to_q    <= to_d;
      rdy_q   <= rx_ready_i;
    end
  end

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    gen     = 1'b0;
    gen_brk = 1'b0;
    gen_ext = 1'b0;
    if (stb) begin
      case (state_q)
        S_IDLE: begin
          case (rx_data_i)
            8'hE0: state_d = S_E0;
            8'hF0: state_d = S_F0;
            8'hE1: begin
              state_d = S_SKIP;
              skip_d  = 3'd7;
            end
            8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hFE: state_d = S_IDLE;
            default: gen = 1'b1;
          endcase
        end
        S_E0: begin
          if (rx_data_i == 8'hF0) begin
            state_d = S_E0F0;
          end else if (rx_data_i != 8'hE0) begin
            gen     = 1'b1;
            gen_ext = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_F0: begin
          gen     = 1'b1;
          gen_brk = 1'b1;
          state_d = S_IDLE;
        end
        S_E0F0: begin
          gen     = 1'b1;
          gen_brk = 1'b1;
          gen_ext = 1'b1;
          state_d = S_IDLE;
        end
        S_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && to_q == TO_LAST) begin
      state_d = S_IDLE;
    end
  end

  // Counter only runs while a prefix is pending and no byte arrives.
  always_comb begin
    if (stb || state_q == S_IDLE || to_q == TO_LAST) to_d = '0;
    else                                             to_d = to_q + TW'(1);
  end

  assign key_match = (held_key_q == {gen_ext, rx_data_i});
  assign push      = gen & (gen_brk | ~(held_vld_q & key_match));

  always_comb begin
    held_vld_d = held_vld_q;
    held_key_d = held_key_q;
    if (gen && !gen_brk && !(held_vld_q && key_match)) begin
      held_vld_d = 1'b1;
      held_key_d = {gen_ext, rx_data_i};
    end else if (gen && gen_brk && key_match) begin
      held_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      held_vld_q <= 1'b0;
      held_key_q <= '0;
    end else begin
      held_vld_q <= held_vld_d;
      held_key_q <= held_key_d;
    end
  end

  assign count = wr_q - rd_q;
  assign full  = (count == DEPTH_C);
  assign pop   = (count != '0) & ev_ready_i;
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q[AW-1:0]] <= {gen_brk, gen_ext, rx_data_i};
        wr_q                <= wr_q + (AW + 1)'(1);
      end
      if (pop) rd_q <= rd_q + (AW + 1)'(1);
      // Clear has priority over a same-cycle loss.
      if (clr_ovf_i)                  ovf_q <= 1'b0;
      else if (push && full && !pop)  ovf_q <= 1'b1;
    end
  end

  assign ev_valid_o = (count != '0);
  assign ev_data_o  = mem_q[rd_q[AW-1:0]];
  assign ev_count_o = count;
  assign overflow_o = ovf_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Self-checking bench for kbd_event_ctrl: directed scenarios plus a random
// byte stream compared against a flag/queue based model of the parser.
module tb_kbd_event_ctrl;

  localparam int DEPTH = 8;
  localparam int TO    = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic       ev_valid;
  logic [9:0] ev_data;
  logic       ev_ready = 1'b0;
  logic [3:0] ev_count;
  logic       overflow;
  logic       clr_ovf = 1'b0;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [9:0] exp_q[$];
  bit         m_ext, m_brk, held_v, m_ovf;
  int         m_skip;
  logic [8:0] held;

  kbd_event_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_ready_i(rx_ready),
    .ev_valid_o(ev_valid), .ev_data_o(ev_data), .ev_ready_i(ev_ready),
    .ev_count_o(ev_count), .overflow_o(overflow), .clr_ovf_i(clr_ovf),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit m_busy();
    return m_ext | m_brk | (m_skip > 0);
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_ext = 0; m_brk = 0; m_skip = 0; held_v = 0; held = '0; m_ovf = 0;
  endfunction

  function automatic void model_emit(bit brk, bit ext, logic [7:0] code);
    logic [8:0] k;
    k = {ext, code};
    if (!brk) begin
      if (held_v && held == k) return;
      held_v = 1;
      held   = k;
    end else if (held_v && held == k) begin
      held_v = 0;
    end
    if (exp_q.size() >= DEPTH) m_ovf = 1;
    else exp_q.push_back({brk, k});
  endfunction

  function automatic void model_byte(logic [7:0] b);
    if (m_skip > 0) begin
      m_skip--;
      return;
    end
    if (m_brk) begin
      model_emit(1'b1, m_ext, b);
      m_brk = 0;
      m_ext = 0;
    end else if (m_ext) begin
      if (b == 8'hF0) m_brk = 1;
      else if (b != 8'hE0) begin
        model_emit(1'b0, 1'b1, b);
        m_ext = 0;
      end
    end else begin
      case (b)
        8'hE0: m_ext = 1;
        8'hF0: m_brk = 1;
        8'hE1: m_skip = 7;
        8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hFE: ;
        default: model_emit(1'b0, 1'b0, b);
      endcase
    end
  endfunction

  // Entered and left just after a falling edge; rx_ready held for 'hold' clocks.
  task automatic send_byte(input logic [7:0] b, input int hold = 1);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    model_byte(b);
    n_checks++;
    if (busy !== m_busy()) begin
      n_fail++;
      $display("FAIL byte_busy: byte %h got %b expected %b", b, busy, m_busy());
    end
    n_checks++;
    if (ev_valid !== (exp_q.size() != 0)) begin
      n_fail++;
      $display("FAIL byte_valid: byte %h got %b expected %b", b, ev_valid, exp_q.size() != 0);
    end
    repeat (hold - 1) @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ev_count !== 4'(exp_q.size())) begin
      n_fail++;
      $display("FAIL byte_count: byte %h got %0d expected %0d", b, ev_count, exp_q.size());
    end
  endtask

  task automatic drain_one();
    n_checks++;
    if (ev_valid !== 1'b1 || ev_data !== exp_q[0]) begin
      n_fail++;
      $display("FAIL pop_head: got valid %b data %h expected valid 1 data %h", ev_valid, ev_data, exp_q[0]);
    end
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    void'(exp_q.pop_front());
    n_checks++;
    if (ev_count !== 4'(exp_q.size())) begin
      n_fail++;
      $display("FAIL pop_count: got %0d expected %0d", ev_count, exp_q.size());
    end
  endtask

  task automatic drain_all();
    while (exp_q.size() > 0) drain_one();
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    n_checks++;
    if (ev_valid !== 1'b0 || ev_count !== 4'd0) begin
      n_fail++;
      $display("FAIL drain_empty: got valid %b count %0d expected 0 0", ev_valid, ev_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks++;
    if ({ev_valid, ev_data, ev_count, overflow, busy} !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid %b data %h count %0d ovf %b busy %b expected all 0",
               ev_valid, ev_data, ev_count, overflow, busy);
    end
  endtask

  task automatic test_make_break();
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1C, 3);
    n_checks++;
    if (exp_q.size() != 2 || ev_data !== 10'h01C) begin
      n_fail++;
      $display("FAIL make_break_head: got %h count %0d expected 01c", ev_data, ev_count);
    end
    drain_all();
  endtask

  task automatic test_extended();
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hE0); send_byte(8'h75);
    drain_all();
  endtask

  task automatic test_repeat();
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C); send_byte(8'h1C);
    drain_all();
  endtask

  task automatic test_pause();
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    send_byte(8'h12);
    send_byte(8'hF0); send_byte(8'h12);
    drain_all();
    for (int i = 0; i < 8; i++) send_byte(seq[i]);
    send_byte(8'hAA);
    send_byte(8'hFA);
    send_byte(8'h1C);
    drain_all();
  endtask

  task automatic test_timeout();
    send_byte(8'h12);
    send_byte(8'hF0);
    repeat (TO - 2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_early: got busy %b expected 1", busy);
    end
    @(negedge clk);
    m_brk = 0; m_ext = 0; m_skip = 0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_f0: got busy %b expected 0", busy);
    end
    send_byte(8'h1C);
    send_byte(8'hE1);
    repeat (TO - 1) @(negedge clk);
    m_skip = 0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_skip: got busy %b expected 0", busy);
    end
    send_byte(8'h75);
    drain_all();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) send_byte(8'h15 + 8'(i));
    n_checks++;
    if (ev_count !== 4'd8 || overflow !== 1'b1 || ev_data !== 10'h015) begin
      n_fail++;
      $display("FAIL ovf_full: got count %0d ovf %b head %h expected 8 1 015", ev_count, overflow, ev_data);
    end
    rx_data = 8'h2A; rx_ready = 1'b1; ev_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0; ev_ready = 1'b0;
    void'(exp_q.pop_front());
    model_byte(8'h2A);
    n_checks++;
    if (ev_count !== 4'd8 || overflow !== m_ovf || ev_data !== exp_q[0]) begin
      n_fail++;
      $display("FAIL ovf_push_pop: got count %0d ovf %b head %h expected 8 %b %h",
               ev_count, overflow, ev_data, m_ovf, exp_q[0]);
    end
    @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    m_ovf = 0;
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b expected 0", overflow);
    end
    rx_data = 8'h2B; rx_ready = 1'b1; clr_ovf = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0; clr_ovf = 1'b0;
    model_byte(8'h2B);
    m_ovf = 0;
    n_checks++;
    if (overflow !== 1'b0 || ev_count !== 4'd8) begin
      n_fail++;
      $display("FAIL ovf_clr_wins: got ovf %b count %0d expected 0 8", overflow, ev_count);
    end
    @(negedge clk);
    drain_all();
  endtask

  task automatic test_random();
    logic [7:0] common [4] = '{8'h1C, 8'h75, 8'h14, 8'h12};
    logic [7:0] b;
    int r;
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      b = common[$urandom_range(0, 3)];
      else if (r < 62) b = 8'hF0;
      else if (r < 74) b = 8'hE0;
      else if (r < 77) b = 8'hE1;
      else             b = 8'($urandom_range(0, 255));
      send_byte(b, $urandom_range(1, 3));
      if (exp_q.size() > 0 && $urandom_range(0, 2) == 0) drain_one();
    end
    n_checks++;
    if (overflow !== m_ovf) begin
      n_fail++;
      $display("FAIL rand_ovf: got %b expected %b", overflow, m_ovf);
    end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    m_ovf = 0;
    // flush any half-finished sequence so the drain sees only queued events
    repeat (TO + 2) @(negedge clk);
    m_ext = 0; m_brk = 0; m_skip = 0;
    drain_all();
  endtask

  task automatic test_reset_mid();
    send_byte(8'h1C);
    send_byte(8'hE0);
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || ev_valid !== 1'b0 || ev_count !== 4'd0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy %b valid %b count %0d ovf %b expected 0 0 0 0",
               busy, ev_valid, ev_count, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    send_byte(8'h1C);
    drain_all();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_make_break();
    test_extended();
    test_repeat();
    test_pause();
    test_timeout();
    test_overflow();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
